// File: rtl/comparator_nbit_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator (signed/unsigned), SLICE bits per cycle from the MSB, early exit on the first unequal slice.
// Latency: done in cycle k+1 after a start (k = slices examined); start is accepted only in IDLE, and a start while busy is dropped.
module comparator_nbit_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic [IDXW-1:0]  idx_q;
  logic             busy_q, done_q, lt_q, gt_q, eq_q;
  logic [SLICE-1:0] slice_a, slice_b;

  // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        slice_a = a_q[i*SLICE +: SLICE];
        slice_b = b_q[i*SLICE +: SLICE];
      end
    end
    if (sm_q && (idx_q == TOP_IDX)) begin
      slice_a[SLICE-1] = ~slice_a[SLICE-1];
      slice_b[SLICE-1] = ~slice_b[SLICE-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sm_q    <= signed_mode;
            idx_q   <= TOP_IDX;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (slice_a > slice_b) begin
            gt_q    <= 1'b1;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (slice_a < slice_b) begin
            lt_q    <= 1'b1;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_comparator_nbit_seq.sv
// Directed bench for comparator_nbit_seq at WIDTH=8, SLICE=2; cycle 0 is the start cycle, sampled 1 time unit after each rising edge.
module tb_comparator_nbit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] a, b;
  logic       busy, done, lt, gt, eq;

  int checks   = 0;
  int failures = 0;

  comparator_nbit_seq #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .lt(lt), .gt(gt), .eq(eq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one compare from IDLE and record the done cycle (-1 on timeout) and busy cycles.
  task automatic go(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                    output int dcyc, output logic [15:0] bmask);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    dcyc = -1; bmask = '0;
    for (int c = 1; c < 16 && dcyc < 0; c++) begin
      tick();
      start = 1'b0;
      if (busy === 1'b1) bmask[c] = 1'b1;
      if (done === 1'b1) dcyc = c;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; signed_mode = 1'b1; a = 8'h12; b = 8'h34;
    tick();
    tick();
    checks++;
    if ({busy, done, lt, gt, eq} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {busy, done, lt, gt, eq});
    end
    start = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, done, lt, gt, eq} !== 5'b0) begin
      failures++;
      $display("FAIL reset_no_capture got=%b exp=00000", {busy, done, lt, gt, eq});
    end
  endtask

  task automatic test_early_exit();
    int d; logic [15:0] bm;
    go(8'hC0, 8'h40, 1'b0, d, bm);
    checks++;
    if (d !== 2 || bm !== 16'h0002) begin
      failures++;
      $display("FAIL early_unsigned_timing done=%0d busy=%h exp done=2 busy=0002", d, bm);
    end
    checks++;
    if ({lt, gt, eq} !== 3'b010) begin
      failures++;
      $display("FAIL early_unsigned_result ltgteq=%b exp=010", {lt, gt, eq});
    end
    tick();
    go(8'hC0, 8'h40, 1'b1, d, bm);
    checks++;
    if (d !== 2) begin
      failures++;
      $display("FAIL early_signed_done got=%0d exp=2", d);
    end
    checks++;
    if ({lt, gt, eq} !== 3'b100) begin
      failures++;
      $display("FAIL early_signed_result ltgteq=%b exp=100", {lt, gt, eq});
    end
    tick();
  endtask

  task automatic test_equal();
    int d; logic [15:0] bm;
    go(8'hA5, 8'hA5, 1'b0, d, bm);
    checks++;
    if (d !== 5 || bm !== 16'h001E) begin
      failures++;
      $display("FAIL equal_timing done=%0d busy=%h exp done=5 busy=001e", d, bm);
    end
    checks++;
    if ({lt, gt, eq} !== 3'b001) begin
      failures++;
      $display("FAIL equal_result ltgteq=%b exp=001", {lt, gt, eq});
    end
    tick();
  endtask

  task automatic test_lsb_decides();
    int d; logic [15:0] bm;
    go(8'h12, 8'h13, 1'b0, d, bm);
    checks++;
    if (d !== 5 || {lt, gt, eq} !== 3'b100) begin
      failures++;
      $display("FAIL lsb_unsigned done=%0d ltgteq=%b exp done=5 ltgteq=100", d, {lt, gt, eq});
    end
    tick();
    go(8'hFF, 8'hFE, 1'b1, d, bm);
    checks++;
    if (d !== 5 || {lt, gt, eq} !== 3'b010) begin
      failures++;
      $display("FAIL lsb_signed done=%0d ltgteq=%b exp done=5 ltgteq=010", d, {lt, gt, eq});
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int dcnt = 0;
    a = 8'h00; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
    // Keep start high with new operands through RUN and DONE; the DONE-cycle start
    // is still high in the following IDLE cycle, which begins the next compare.
    for (int c = 1; c <= 5; c++) begin
      tick();
      a = 8'hFF; b = 8'h00; start = 1'b1;
      if (done === 1'b1) dcnt++;
    end
    checks++;
    if (done !== 1'b1 || dcnt !== 1 || {lt, gt, eq} !== 3'b001) begin
      failures++;
      $display("FAIL ignore_first_result done=%b pulses=%0d ltgteq=%b exp 1 1 001", done, dcnt, {lt, gt, eq});
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {lt, gt, eq} !== 3'b001) begin
      failures++;
      $display("FAIL ignore_idle_hold busy=%b done=%b ltgteq=%b exp 0 0 001", busy, done, {lt, gt, eq});
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || {lt, gt, eq} !== 3'b001) begin
      failures++;
      $display("FAIL ignore_run_hold busy=%b done=%b ltgteq=%b exp 1 0 001", busy, done, {lt, gt, eq});
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {lt, gt, eq} !== 3'b010) begin
      failures++;
      $display("FAIL ignore_next_accept done=%b busy=%b ltgteq=%b exp 1 0 010", done, busy, {lt, gt, eq});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int d; logic [15:0] bm;
    go(8'h12, 8'h13, 1'b0, d, bm);
    tick();
    go(8'h80, 8'h7F, 1'b1, d, bm);
    checks++;
    if (d !== 2 || {lt, gt, eq} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_second done=%0d ltgteq=%b exp done=2 ltgteq=100", d, {lt, gt, eq});
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int d; int stray = 0; logic [15:0] bm;
    a = 8'hA5; b = 8'hA5; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, lt, gt, eq} !== 5'b0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=00000", {busy, done, lt, gt, eq});
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL midreset_quiet stray_cycles=%0d exp=0", stray);
    end
    go(8'h40, 8'hC0, 1'b0, d, bm);
    checks++;
    if (d !== 2 || {lt, gt, eq} !== 3'b100) begin
      failures++;
      $display("FAIL midreset_recover done=%0d ltgteq=%b exp done=2 ltgteq=100", d, {lt, gt, eq});
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #1;
    test_reset();
    test_early_exit();
    test_equal();
    test_lsb_decides();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
